parity_frame_unit: RTL and testbench
====================================

# parity_frame_unit

Parametrised, clocked successor to the team's fixed 3-input, dual-output parity cell. The block accepts a stream of DATA_W-bit words over a valid/ready handshake and accumulates per-lane parity across a frame. At frame end it emits each lane's parity bit, or in check mode a per-lane mismatch flag. It sits between a word source and a protection/status sink.

## Interface
- DATA_W, 8: input word width; must be a multiple of LANES.
- LANES, 2: number of independent parity lanes. Lane k covers in_data[k*LW +: LW], where LW = DATA_W/LANES.
- MAX_WORDS, 16: maximum words per frame; must be at least 2.
- ERR_CNT_W, 8: width of the error counter.
- clk, in, 1: clock. All logic is rising-edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- in_valid, in, 1: input word valid.
- in_ready, out, 1: block can accept a word.
- in_data, in, DATA_W: input word.
- in_last, in, 1: marks the final word of the frame.
- in_chk, in, LANES: expected per-lane parity. Sampled only on the in_last beat.
- odd_mode, in, 1: 0 = even parity, 1 = odd parity. Latched on the first beat of each frame.
- check_mode, in, 1: 0 = generate, 1 = check. Latched on the first beat of each frame.
- out_valid, out, 1: frame result valid.
- out_ready, in, 1: sink accepts the result.
- out_par, out, LANES: generate mode = lane parity; check mode = lane mismatch mask.
- out_err, out, 1: check mode only; OR of the mismatch mask. Always 0 in generate mode.
- out_trunc, out, 1: frame was closed by reaching MAX_WORDS, not by in_last.
- out_len, out, clog2(MAX_WORDS+1): number of words in the frame.
- err_cnt, out, ERR_CNT_W: saturating count of errored frames. Present only when the configuration macro is defined.

## Operation
- States are IDLE, ACCUM and EMIT. A beat is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in EMIT.
- IDLE, on an accepted beat:
  - latch odd_mode and check_mode;
  - acc = lane parity of the word;
  - len = 1;
  - go to ACCUM; if in_last is set, go straight to EMIT.
- ACCUM, on an accepted beat:
  - acc ^= lane parity of the word;
  - len += 1;
  - go to EMIT if in_last is set, or if the new len equals MAX_WORDS. In the MAX_WORDS case set trunc.
- Entry to EMIT (registered outputs):
  - generate mode: out_par = acc ^ {LANES{odd}};
  - check mode: out_par = (acc ^ {LANES{odd}}) ^ in_chk, and out_err = |out_par;
  - on a truncated frame in check mode, in_chk is not sampled and out_err is forced to 1.
- EMIT: hold out_valid and all result fields stable until out_ready is seen, then go to IDLE. There is no bubble requirement beyond the handshake.
- Reset values: state IDLE, all outputs 0 (out_valid, out_par, out_err, out_trunc, out_len, err_cnt), internal acc/len/mode latches 0.
- A reset asserted mid-frame or in EMIT discards the frame. No result is emitted.
- Changes to odd_mode or check_mode mid-frame are ignored until the next frame.

## Timing
- Latency: out_valid rises on the clock edge that accepts the closing beat. Results are visible the same cycle out_valid is high.
- Throughput: one word per cycle in ACCUM. Each frame costs at least one EMIT cycle, during which in_ready = 0.
- out_valid falls on the edge where out_valid && out_ready. in_ready rises on that same edge.
- A single-word frame (in_last on the first beat) goes IDLE -> EMIT in one edge.
- in_last arriving exactly on beat MAX_WORDS closes the frame normally, with out_trunc = 0.

## Configuration
- Macro PARITY_FRAME_ERR_CNT_EN.
- Defined: the err_cnt port and counter exist. The counter increments by 1 on each EMIT handshake where out_err = 1, saturates at all-ones, and is cleared only by reset.
- Undefined: no err_cnt port and no counter logic. All other behaviour is identical.

## Structure
- Shared package parity_pkg holds:
  - the state enum (IDLE, ACCUM, EMIT);
  - a lane-width helper function;
  - the length-width localparam derivation.
- One sub-module, parity_lane_reduce: combinational, parameterised by DATA_W and LANES, outputs the per-lane XOR reduction of a word. It is instantiated once.

## Test plan
All scenarios use DATA_W=8, LANES=2, MAX_WORDS=4.
- Generate, even, frame {0xA5, 0x13(last)}: out_par=2'b10, out_len=2, out_err=0, out_trunc=0.
- Same frame with odd_mode=1 on the first beat, toggled to 0 on the second: out_par=2'b01 (mode latched at frame start).
- Check, even, frame {0xA5, 0x13(last, in_chk=2'b11)}: out_par=2'b01, out_err=1, err_cnt goes 0 -> 1. Repeat with in_chk=2'b10: out_err=0, err_cnt unchanged.
- Five words 0x07 with no in_last, generate even: first result has out_len=4, out_trunc=1, out_par=2'b00. The fifth word starts a new frame.
- Single-word frame 0x07(last) with out_ready held low for 3 cycles: out_valid=1 and out_par=2'b01 stable for 3 cycles, in_ready=0 throughout. Handshake completes on the 4th cycle.
- rst_n pulsed low after 2 beats of a 3-word frame: all outputs are 0 immediately, no out_valid follows, and the next frame's result reflects only post-reset words.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and width helpers for the parity frame unit.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_e;

  function automatic int unsigned lane_width(input int unsigned data_w,
                                             input int unsigned lanes);
    return data_w / lanes;
  endfunction

  // Frame length counts 1..MAX_WORDS, so the field needs clog2(MAX_WORDS+1) bits.
  function automatic int unsigned len_width(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/parity_lane_reduce.sv
// Combinational per-lane XOR reduction of one input word.
module parity_lane_reduce
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [LANES-1:0]  par_o
);

  localparam int unsigned LW = lane_width(DATA_W, LANES);

  always_comb begin
    par_o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      par_o[k] = ^data_i[k*LW +: LW];
    end
  end

endmodule

// File: rtl/parity_frame_unit.sv
// Frame-level per-lane parity generator/checker with valid/ready handshakes.
// Optional saturating errored-frame counter enabled by PARITY_FRAME_ERR_CNT_EN.
module parity_frame_unit
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LANES     = 2,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_last,
  input  logic [LANES-1:0]                 in_chk,
  input  logic                             odd_mode,
  input  logic                             check_mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0]                 out_par,
  output logic                             out_err,
  output logic                             out_trunc,
`ifdef PARITY_FRAME_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]             err_cnt,
`endif
  output logic [len_width(MAX_WORDS)-1:0]  out_len
);

  localparam int unsigned LEN_W = len_width(MAX_WORDS);

  state_e             state_q;
  logic [LANES-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               odd_q, chk_q;
  logic               out_valid_q, out_err_q, out_trunc_q;
  logic [LANES-1:0]   out_par_q;
  logic [LEN_W-1:0]   out_len_q;

  logic [LANES-1:0]   word_par;
  logic               accept;
  logic               odd_eff, chk_eff;
  logic               hit_max, close_frame, trunc_d;
  logic [LANES-1:0]   par_base;

  parity_lane_reduce #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_reduce (
    .data_i (in_data),
    .par_o  (word_par)
  );

  assign in_ready = (state_q != EMIT);
  assign accept   = in_valid && in_ready;

  // The first beat of a frame must see the live mode inputs, later beats the latched copy.
  always_comb begin
    odd_eff     = (state_q == IDLE) ? odd_mode   : odd_q;
    chk_eff     = (state_q == IDLE) ? check_mode : chk_q;
    acc_d       = (state_q == IDLE) ? word_par   : (acc_q ^ word_par);
    len_d       = (state_q == IDLE) ? LEN_W'(1)  : (len_q + LEN_W'(1));
    hit_max     = (state_q == ACCUM) && (len_d == LEN_W'(MAX_WORDS));
    close_frame = in_last || hit_max;
    trunc_d     = hit_max && !in_last;
    par_base    = acc_d ^ {LANES{odd_eff}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      len_q       <= '0;
      odd_q       <= 1'b0;
      chk_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_par_q   <= '0;
      out_err_q   <= 1'b0;
      out_trunc_q <= 1'b0;
      out_len_q   <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            len_q <= len_d;
            if (state_q == IDLE) begin
              odd_q <= odd_mode;
              chk_q <= check_mode;
            end
            if (close_frame) begin
              state_q     <= EMIT;
              out_valid_q <= 1'b1;
              out_len_q   <= len_d;
              out_trunc_q <= trunc_d;
              if (chk_eff) begin
                // A truncated check frame never saw in_chk, so it is flagged as errored.
                out_par_q <= trunc_d ? par_base : (par_base ^ in_chk);
                out_err_q <= trunc_d | (|(par_base ^ in_chk));
              end else begin
                out_par_q <= par_base;
                out_err_q <= 1'b0;
              end
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign out_trunc = out_trunc_q;
  assign out_len   = out_len_q;

`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if ((state_q == EMIT) && out_ready && out_err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_unit.sv
// Directed, table-driven bench for parity_frame_unit (DATA_W=8, LANES=2, MAX_WORDS=4).
module tb_parity_frame_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic [1:0] in_chk = '0;
  logic       odd_mode = 1'b0;
  logic       check_mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_par;
  logic       out_err;
  logic       out_trunc;
  logic [2:0] out_len;
`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int e_cnt = 0;

  always #5 clk = ~clk;

  parity_frame_unit #(
    .DATA_W    (8),
    .LANES     (2),
    .MAX_WORDS (4),
    .ERR_CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_chk     (in_chk),
    .odd_mode   (odd_mode),
    .check_mode (check_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_par    (out_par),
    .out_err    (out_err),
    .out_trunc  (out_trunc),
`ifdef PARITY_FRAME_ERR_CNT_EN
    .err_cnt    (err_cnt),
`endif
    .out_len    (out_len)
  );

  typedef struct {
    logic [3:0][7:0] w;
    int              n;
    logic            last;
    logic            odd;
    logic            toggle;
    logic            chk_m;
    logic [1:0]      chk;
    logic [1:0]      e_par;
    logic            e_err;
    logic            e_trunc;
    logic [2:0]      e_len;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef PARITY_FRAME_ERR_CNT_EN
    check(name, 32'(err_cnt), 32'(e_cnt));
`endif
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, ".valid_fall"}, 32'(out_valid), 32'd0);
    check({name, ".ready_rise"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    string nm;
    v  = vecs[idx];
    nm = $sformatf("vec%0d", idx);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      in_data    = v.w[i];
      in_last    = v.last && (i == v.n - 1);
      odd_mode   = (i == 0 || !v.toggle) ? v.odd : ~v.odd;
      check_mode = (i == 0) ? v.chk_m : ~v.chk_m;
      in_chk     = (i == v.n - 1) ? v.chk : ~v.chk;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({nm, ".out_valid"}, 32'(out_valid), 32'd1);
    check({nm, ".in_ready"}, 32'(in_ready), 32'd0);
    check({nm, ".out_par"}, 32'(out_par), 32'(v.e_par));
    check({nm, ".out_err"}, 32'(out_err), 32'(v.e_err));
    check({nm, ".out_trunc"}, 32'(out_trunc), 32'(v.e_trunc));
    check({nm, ".out_len"}, 32'(out_len), 32'(v.e_len));
    handshake(nm);
    if (v.e_err) e_cnt++;
    check_cnt({nm, ".err_cnt"});
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = d;
    in_last    = last;
    odd_mode   = 1'b0;
    check_mode = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{w: {8'h00, 8'h00, 8'h13, 8'hA5}, n: 2, last: 1, odd: 0, toggle: 0, chk_m: 0, chk: 2'b00, e_par: 2'b10, e_err: 0, e_trunc: 0, e_len: 3'd2};
    vecs[1] = '{w: {8'h00, 8'h00, 8'h13, 8'hA5}, n: 2, last: 1, odd: 1, toggle: 1, chk_m: 0, chk: 2'b00, e_par: 2'b01, e_err: 0, e_trunc: 0, e_len: 3'd2};
    vecs[2] = '{w: {8'h00, 8'h00, 8'h13, 8'hA5}, n: 2, last: 1, odd: 0, toggle: 0, chk_m: 1, chk: 2'b11, e_par: 2'b01, e_err: 1, e_trunc: 0, e_len: 3'd2};
    vecs[3] = '{w: {8'h00, 8'h00, 8'h13, 8'hA5}, n: 2, last: 1, odd: 0, toggle: 0, chk_m: 1, chk: 2'b10, e_par: 2'b00, e_err: 0, e_trunc: 0, e_len: 3'd2};
    vecs[4] = '{w: {8'h07, 8'h07, 8'h07, 8'h07}, n: 4, last: 1, odd: 0, toggle: 0, chk_m: 0, chk: 2'b00, e_par: 2'b00, e_err: 0, e_trunc: 0, e_len: 3'd4};
    vecs[5] = '{w: {8'h07, 8'h07, 8'h07, 8'h07}, n: 4, last: 0, odd: 0, toggle: 0, chk_m: 1, chk: 2'b11, e_par: 2'b00, e_err: 1, e_trunc: 1, e_len: 3'd4};
    vecs[6] = '{w: {8'h00, 8'h00, 8'h00, 8'h07}, n: 1, last: 1, odd: 1, toggle: 0, chk_m: 0, chk: 2'b00, e_par: 2'b10, e_err: 0, e_trunc: 0, e_len: 3'd1};
    vecs[7] = '{w: {8'h00, 8'h01, 8'h80, 8'hFF}, n: 3, last: 1, odd: 1, toggle: 0, chk_m: 0, chk: 2'b00, e_par: 2'b00, e_err: 0, e_trunc: 0, e_len: 3'd3};

    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_par", 32'(out_par), 32'd0);
    check("rst.out_len", 32'(out_len), 32'd0);
    check("rst.out_trunc", 32'(out_trunc), 32'd0);
    check("rst.out_err", 32'(out_err), 32'd0);
    check_cnt("rst.err_cnt");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Five words without in_last: truncation at 4, fifth word opens a new frame.
    for (int i = 0; i < 4; i++) beat(8'h07, 1'b0);
    check("trunc.out_valid", 32'(out_valid), 32'd1);
    check("trunc.in_ready", 32'(in_ready), 32'd0);
    check("trunc.out_len", 32'(out_len), 32'd4);
    check("trunc.out_trunc", 32'(out_trunc), 32'd1);
    check("trunc.out_par", 32'(out_par), 32'd0);
    check("trunc.out_err", 32'(out_err), 32'd0);
    in_data = 8'h07;
    handshake("trunc");
    @(posedge clk); #1;
    check("trunc.fifth_open", 32'(out_valid), 32'd0);
    beat(8'h00, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("trunc2.out_valid", 32'(out_valid), 32'd1);
    check("trunc2.out_len", 32'(out_len), 32'd2);
    check("trunc2.out_par", 32'(out_par), 32'd1);
    check("trunc2.out_trunc", 32'(out_trunc), 32'd0);
    handshake("trunc2");

    // Single-word frame with the sink stalled for three cycles.
    beat(8'h07, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d.out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d.out_par", c), 32'(out_par), 32'd1);
      check($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d.out_len", c), 32'(out_len), 32'd1);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    handshake("stall");

    // Reset mid-frame discards the partial frame and clears held results.
    beat(8'h0F, 1'b0);
    beat(8'hF0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    e_cnt = 0;
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.out_par", 32'(out_par), 32'd0);
    check("mrst.out_len", 32'(out_len), 32'd0);
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    check_cnt("mrst.err_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("mrst.idle%0d", c), 32'(out_valid), 32'd0);
    end
    beat(8'h01, 1'b0);
    check("post.mid_valid", 32'(out_valid), 32'd0);
    beat(8'h10, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("post.out_valid", 32'(out_valid), 32'd1);
    check("post.out_par", 32'(out_par), 32'd3);
    check("post.out_len", 32'(out_len), 32'd2);
    check("post.out_trunc", 32'(out_trunc), 32'd0);
    handshake("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
